// File: rtl/challenge_gen.sv
// Reaction/guessing game challenge generator: issues LFSR-derived 4-bit challenges,
// judges player guesses or timer expiry, and tracks rounds per game.
module challenge_gen #(
   parameter int         ROUND_TIMEOUT = 20,
   parameter int         NUM_ROUNDS    = 10,
   parameter logic [3:0] LFSR_SEED     = 4'b1001
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       submit,
   input  logic [3:0] user_input,
   output logic [3:0] random_number,
   output logic       challenge_valid,
   output logic       hit,
   output logic       miss,
   output logic       timeout,
   output logic [3:0] round_cnt,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [3:0] ROUNDS_C     = 4'(NUM_ROUNDS);
   localparam logic [7:0] TIMER_LAST_C = 8'(ROUND_TIMEOUT - 1);

   state_t     state_r, state_s;
   logic [3:0] lfsr_r, lfsr_s;
   logic [7:0] timer_r, timer_s;
   logic [3:0] random_number_s, round_cnt_s;
   logic       challenge_valid_s, hit_s, miss_s, timeout_s, game_over_s;
   logic       resolve_s, last_round_s;

   function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
      return {cur[2:0], cur[3] ^ cur[2]};
   endfunction

   // Next-state and registered-output values; a resolution is shared by submit and expiry.
   always_comb begin
      state_s           = state_r;
      lfsr_s            = lfsr_r;
      timer_s           = timer_r;
      random_number_s   = random_number;
      challenge_valid_s = challenge_valid;
      hit_s             = 1'b0;
      miss_s            = 1'b0;
      timeout_s         = 1'b0;
      round_cnt_s       = round_cnt;
      game_over_s       = game_over;
      resolve_s         = 1'b0;
      last_round_s      = ((round_cnt + 4'd1) == ROUNDS_C);

      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            random_number_s   = lfsr_r;
            lfsr_s            = lfsr_next(lfsr_r);
            timer_s           = 8'd0;
            challenge_valid_s = 1'b1;
            state_s           = WAIT;
         end
         WAIT: begin
            // A submit on the expiry cycle is judged by compare, never as a timeout.
            if (submit) begin
               resolve_s = 1'b1;
               hit_s     = (user_input == random_number);
               miss_s    = (user_input != random_number);
            end else if (timer_r == TIMER_LAST_C) begin
               resolve_s = 1'b1;
               miss_s    = 1'b1;
               timeout_s = 1'b1;
            end else begin
               timer_s = timer_r + 8'd1;
            end
         end
         DONE: begin
            if (start) begin
               round_cnt_s = 4'd0;
               game_over_s = 1'b0;
               state_s     = ISSUE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      if (resolve_s) begin
         challenge_valid_s = 1'b0;
         round_cnt_s       = round_cnt + 4'd1;
         if (last_round_s) begin
            state_s     = DONE;
            game_over_s = 1'b1;
         end else begin
            state_s = ISSUE;
         end
      end else begin
         resolve_s = 1'b0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= IDLE;
         lfsr_r          <= LFSR_SEED;
         timer_r         <= 8'd0;
         random_number   <= 4'd0;
         challenge_valid <= 1'b0;
         hit             <= 1'b0;
         miss            <= 1'b0;
         timeout         <= 1'b0;
         round_cnt       <= 4'd0;
         game_over       <= 1'b0;
      end else begin
         state_r         <= state_s;
         lfsr_r          <= lfsr_s;
         timer_r         <= timer_s;
         random_number   <= random_number_s;
         challenge_valid <= challenge_valid_s;
         hit             <= hit_s;
         miss            <= miss_s;
         timeout         <= timeout_s;
         round_cnt       <= round_cnt_s;
         game_over       <= game_over_s;
      end
   end

endmodule

// File: tb/tb_challenge_gen.sv
// Directed bench for challenge_gen: bench-side LFSR model plus a result scoreboard
// whose expected {hit,miss,timeout} entries are popped whenever the DUT pulses.
module tb_challenge_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       submit;
   logic [3:0] user_input;
   logic [3:0] random_number;
   logic       challenge_valid;
   logic       hit;
   logic       miss;
   logic       timeout;
   logic [3:0] round_cnt;
   logic       game_over;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];
   logic [3:0] model_lfsr;
   logic [3:0] cur_chal;
   logic [2:0] popped;

   challenge_gen #(
      .ROUND_TIMEOUT(20),
      .NUM_ROUNDS   (3),
      .LFSR_SEED    (4'b1001)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .submit         (submit),
      .user_input     (user_input),
      .random_number  (random_number),
      .challenge_valid(challenge_valid),
      .hit            (hit),
      .miss           (miss),
      .timeout        (timeout),
      .round_cnt      (round_cnt),
      .game_over      (game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every DUT pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (hit || miss || timeout) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {5'd0, hit, miss, timeout}, 8'd0);
         end else begin
            popped = exp_q.pop_front();
            check("result_hmt", {5'd0, hit, miss, timeout}, {5'd0, popped});
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic next_challenge();
      step();
      check("challenge_valid", 8'(challenge_valid), 8'd1);
      check("challenge_value", 8'(random_number), 8'(model_lfsr));
      cur_chal   = model_lfsr;
      model_lfsr = {model_lfsr[2:0], model_lfsr[3] ^ model_lfsr[2]};
   endtask

   task automatic start_game();
      start = 1'b1;
      step();
      start = 1'b0;
      check("issue_cv_low", 8'(challenge_valid), 8'd0);
      check("start_round_cnt", 8'(round_cnt), 8'd0);
      check("start_game_over", 8'(game_over), 8'd0);
      next_challenge();
   endtask

   task automatic answer(input logic [3:0] guess);
      logic h;
      h = (guess === cur_chal);
      exp_q.push_back({h, ~h, 1'b0});
      submit     = 1'b1;
      user_input = guess;
      step();
      submit = 1'b0;
      check("result_latency", 8'(exp_q.size()), 8'd0);
      check("resolved_cv_low", 8'(challenge_valid), 8'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {random_number, challenge_valid, hit, miss, timeout}, 8'd0);
      check(tag, {round_cnt, 3'd0, game_over}, 8'd0);
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      submit     = 1'b0;
      user_input = 4'd0;
      model_lfsr = 4'b1001;
      cur_chal   = 4'd0;
      step();
      check_all_zero("reset_state");
      step();
      reset = 1'b1;
      step();
      check_all_zero("post_release_idle");

      // Game 1: hit, wrong guess, then timeout ending the game.
      start_game();
      answer(cur_chal);
      check("round_cnt_1", 8'(round_cnt), 8'd1);
      next_challenge();
      answer(4'b0010);
      check("round_cnt_2", 8'(round_cnt), 8'd2);
      next_challenge();
      repeat (19) step();
      check("still_waiting", 8'(challenge_valid), 8'd1);
      exp_q.push_back(3'b011);
      step();
      check("timeout_latency", 8'(exp_q.size()), 8'd0);
      check("round_cnt_3", 8'(round_cnt), 8'd3);
      check("game_over", 8'(game_over), 8'd1);
      check("done_cv_low", 8'(challenge_valid), 8'd0);

      // Submit in DONE is ignored.
      submit     = 1'b1;
      user_input = cur_chal;
      step();
      submit = 1'b0;
      check("done_submit_cnt", 8'(round_cnt), 8'd3);
      check("done_hold", 8'(game_over), 8'd1);

      // Game 2 continues the LFSR sequence; start in WAIT is ignored.
      start_game();
      start = 1'b1;
      step();
      start = 1'b0;
      check("wait_start_cnt", 8'(round_cnt), 8'd0);
      check("wait_start_cv", 8'(challenge_valid), 8'd1);
      check("wait_start_value", 8'(random_number), 8'(cur_chal));
      repeat (18) step();
      answer(cur_chal);
      check("expiry_submit_cnt", 8'(round_cnt), 8'd1);

      // Submit during ISSUE is ignored.
      submit     = 1'b1;
      user_input = cur_chal;
      next_challenge();
      submit = 1'b0;
      check("issue_submit_cnt", 8'(round_cnt), 8'd1);

      // Reset in the middle of WAIT abandons the round.
      repeat (3) step();
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      step();
      step();
      check_all_zero("reset_no_pulse");
      reset      = 1'b1;
      model_lfsr = 4'b1001;
      step();
      start_game();
      check("reseeded_first", 8'(cur_chal), 8'h09);

      step();
      check("pending_results", 8'(exp_q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
